// File: rtl/bpred_tbl_ctrl.sv
// Local branch predictor table sequencer: init/clear sweep of BHT+PHT, FIFO-buffered training RMW.
// Latency: sweep 2^BHT_DEPTH cycles; an update takes 4 cycles (IDLE, RD_BHT, RD_PHT, WR) once it reaches the FIFO head.
// Backpressure: none upstream; upd_ready is advisory and updates arriving while full or sweeping are dropped.
// Optional build macro BPRED_TBL_CTRL_STATS_EN adds saturating stat_upd / stat_drop counters.
module bpred_tbl_ctrl #(
  parameter int          BHT_DEPTH = 10,
  parameter int          PHT_DEPTH = 9,
  parameter int          QDEPTH    = 4,
  parameter logic [1:0]  PHT_INIT  = 2'b11
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear_req,
  input  logic                 upd_valid,
  input  logic [31:0]          upd_pc,
  input  logic                 upd_taken,
  output logic                 upd_ready,
  output logic [BHT_DEPTH-1:0] bht_raddr,
  input  logic [5:0]           bht_rdata,
  output logic [PHT_DEPTH-1:0] pht_raddr,
  input  logic [1:0]           pht_rdata,
  output logic                 bht_we,
  output logic [BHT_DEPTH-1:0] bht_waddr,
  output logic [5:0]           bht_wdata,
  output logic                 pht_we,
  output logic [PHT_DEPTH-1:0] pht_waddr,
  output logic [1:0]           pht_wdata,
  output logic                 pred_en,
  output logic                 busy
`ifdef BPRED_TBL_CTRL_STATS_EN
  ,
  output logic [15:0]          stat_upd,
  output logic [15:0]          stat_drop
`endif
);

  // The sweep counter spans the BHT; the PHT (3 pc bits + 6 history bits) is never larger.
  localparam int QAW = $clog2(QDEPTH);

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_RD_BHT, S_RD_PHT, S_WR} state_t;

  state_t                r_state, w_state_nxt;
  logic [BHT_DEPTH-1:0]  r_cnt;
  logic                  r_pred_en;
  logic                  r_clear_pend;
  logic [QAW:0]          r_wptr, r_rptr;
  logic [BHT_DEPTH-1:0]  r_q_idx [QDEPTH];
  logic                  r_q_tkn [QDEPTH];
  logic [BHT_DEPTH-1:0]  r_idx;
  logic                  r_taken;
  logic [5:0]            r_hist;
  logic [BHT_DEPTH-1:0]  r_bht_raddr;
  logic [PHT_DEPTH-1:0]  r_pht_raddr;

  logic                  w_empty, w_full, w_push, w_pop;
  logic                  w_cnt_last, w_cnt_in_pht, w_clr_enter;
  logic [BHT_DEPTH-1:0]  w_head_idx;
  logic                  w_head_tkn;
  logic [1:0]            w_ctr_nxt;
  logic                  w_bht_we, w_pht_we;
  logic [BHT_DEPTH-1:0]  w_bht_waddr;
  logic [5:0]            w_bht_wdata;
  logic [PHT_DEPTH-1:0]  w_pht_waddr;
  logic [1:0]            w_pht_wdata;

  // Only the BHT index bits of the pc are kept; the rest are intentionally ignored.
  logic w_unused_pc;
  assign w_unused_pc = &{1'b0, upd_pc[31:BHT_DEPTH+2], upd_pc[1:0]};

  assign w_empty     = (r_wptr == r_rptr);
  assign w_full      = (r_wptr[QAW] != r_rptr[QAW]) && (r_wptr[QAW-1:0] == r_rptr[QAW-1:0]);
  assign upd_ready   = (r_state != S_INIT) && !w_full;
  assign w_push      = upd_valid && upd_ready;
  assign w_pop       = (r_state == S_RD_BHT);
  assign w_head_idx  = r_q_idx[r_rptr[QAW-1:0]];
  assign w_head_tkn  = r_q_tkn[r_rptr[QAW-1:0]];
  assign w_cnt_last  = (r_cnt == {BHT_DEPTH{1'b1}});
  assign w_cnt_in_pht = ((r_cnt >> PHT_DEPTH) == '0);
  assign w_clr_enter = (r_state == S_IDLE) && (r_clear_pend || clear_req);

  assign pred_en   = r_pred_en;
  assign busy      = (r_state != S_IDLE) || !w_empty || r_clear_pend;
  // Read addresses are live during their read state and otherwise hold the last address issued.
  assign bht_raddr = (r_state == S_RD_BHT) ? w_head_idx : r_bht_raddr;
  assign pht_raddr = (r_state == S_RD_PHT) ? {r_idx[2:0], bht_rdata} : r_pht_raddr;

  // Next-state: sweep, idle dispatch (clear has priority over queued updates), fixed 3-step RMW.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_INIT:   if (w_cnt_last) w_state_nxt = S_IDLE;
      S_IDLE: begin
        if (r_clear_pend || clear_req) w_state_nxt = S_INIT;
        else if (!w_empty)             w_state_nxt = S_RD_BHT;
      end
      S_RD_BHT: w_state_nxt = S_RD_PHT;
      S_RD_PHT: w_state_nxt = S_WR;
      S_WR:     w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_INIT;
    endcase
  end

  // 2-bit counter step; encoding 00 SNT, 01 WNT, 11 WT, 10 ST.
  always_comb begin
    w_ctr_nxt = pht_rdata;
    case ({pht_rdata, r_taken})
      3'b00_1: w_ctr_nxt = 2'b01;
      3'b01_1: w_ctr_nxt = 2'b10;
      3'b11_1: w_ctr_nxt = 2'b10;
      3'b10_1: w_ctr_nxt = 2'b10;
      3'b00_0: w_ctr_nxt = 2'b00;
      3'b01_0: w_ctr_nxt = 2'b00;
      3'b11_0: w_ctr_nxt = 2'b00;
      3'b10_0: w_ctr_nxt = 2'b11;
      default: w_ctr_nxt = pht_rdata;
    endcase
  end

  // Write ports are decoded straight from state so the sweep writes from the very first cycle.
  always_comb begin
    w_bht_we    = 1'b0;
    w_bht_waddr = '0;
    w_bht_wdata = '0;
    w_pht_we    = 1'b0;
    w_pht_waddr = '0;
    w_pht_wdata = '0;
    if (r_state == S_INIT) begin
      w_bht_we    = 1'b1;
      w_bht_waddr = r_cnt;
      w_pht_we    = w_cnt_in_pht;
      w_pht_waddr = r_cnt[PHT_DEPTH-1:0];
      w_pht_wdata = PHT_INIT;
    end else if (r_state == S_WR) begin
      w_bht_we    = 1'b1;
      w_bht_waddr = r_idx;
      w_bht_wdata = {r_hist[4:0], r_taken};
      w_pht_we    = 1'b1;
      w_pht_waddr = {r_idx[2:0], r_hist};
      w_pht_wdata = w_ctr_nxt;
    end
  end

  // Reset is asynchronous, so the write strobes must die with it rather than at the next edge.
  assign bht_we    = rst && w_bht_we;
  assign bht_waddr = rst ? w_bht_waddr : '0;
  assign bht_wdata = rst ? w_bht_wdata : '0;
  assign pht_we    = rst && w_pht_we;
  assign pht_waddr = rst ? w_pht_waddr : '0;
  assign pht_wdata = rst ? w_pht_wdata : '0;

  // Control state: FSM, sweep counter, prediction gate, deferred clear, FIFO pointers, RMW hold regs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_INIT;
      r_cnt        <= '0;
      r_pred_en    <= 1'b0;
      r_clear_pend <= 1'b0;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_idx        <= '0;
      r_taken      <= 1'b0;
      r_hist       <= '0;
      r_bht_raddr  <= '0;
      r_pht_raddr  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_INIT) begin
        r_cnt <= w_cnt_last ? '0 : r_cnt + 1'b1;
        if (w_cnt_last) r_pred_en <= 1'b1;
      end
      if (w_clr_enter) begin
        r_pred_en    <= 1'b0;
        r_clear_pend <= 1'b0;
      end else if (clear_req && r_state != S_INIT) begin
        r_clear_pend <= 1'b1;
      end
      if (w_clr_enter) begin
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + 1'b1;
        if (w_pop)  r_rptr <= r_rptr + 1'b1;
      end
      if (r_state == S_RD_BHT) begin
        r_idx       <= w_head_idx;
        r_taken     <= w_head_tkn;
        r_bht_raddr <= w_head_idx;
      end
      if (r_state == S_RD_PHT) begin
        r_hist      <= bht_rdata;
        r_pht_raddr <= {r_idx[2:0], bht_rdata};
      end
    end
  end

  // FIFO payload storage; validity is carried entirely by the pointers.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_idx[r_wptr[QAW-1:0]] <= upd_pc[BHT_DEPTH+1:2];
      r_q_tkn[r_wptr[QAW-1:0]] <= upd_taken;
    end
  end

`ifdef BPRED_TBL_CTRL_STATS_EN
  logic [15:0] r_stat_upd, r_stat_drop;

  // Saturating event counters; only a hard reset clears them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stat_upd  <= '0;
      r_stat_drop <= '0;
    end else begin
      if (r_state == S_WR && r_stat_upd != 16'hFFFF) r_stat_upd <= r_stat_upd + 1'b1;
      if (upd_valid && !upd_ready && r_stat_drop != 16'hFFFF) r_stat_drop <= r_stat_drop + 1'b1;
    end
  end

  assign stat_upd  = r_stat_upd;
  assign stat_drop = r_stat_drop;
`endif

endmodule
